// File: rtl/led_stream_decoder_pkg.sv
// Shared types and timing for the single-wire LED link. The driver and the
// decoder both take their pulse timing from here so the two ends stay matched.
package led_stream_decoder_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam int LED_BITS = 24;

  // Driver-side pulse shapes at 48 MHz: 0.4 us / 0.8 us high, 1.25 us bit.
  localparam int T0H   = 19;
  localparam int T1H   = 38;
  localparam int T_BIT = 60;

  // Decoder classification defaults.
  localparam int T_THRESH_DEF = 29;
  localparam int T_MIN_HI_DEF = 4;
  localparam int T_MAX_HI_DEF = 72;
  localparam int T_RESET_DEF  = 2400;
  localparam int MAX_PIX_DEF  = 256;

  // Width of a pixel index/count able to hold 0..max_pix.
  function automatic int pix_width(input int max_pix);
    return $clog2(max_pix + 1);
  endfunction

endpackage

// File: rtl/led_stream_decoder_if.sv
// Serial line in, decoded word stream out. The decoder sits on the slave
// side; whoever drives the line and consumes words uses the master side.
interface led_stream_decoder_if
  import led_stream_decoder_pkg::*;
#(
  parameter int PW = pix_width(MAX_PIX_DEF)
);
  logic                din;
  logic [LED_BITS-1:0] rgb_out;
  logic                valid;
  logic [PW-1:0]       pixel_idx;
  logic                frame_done;
  logic [PW-1:0]       pixel_count;
  logic                err;

  modport master (
    output din,
    input  rgb_out, valid, pixel_idx, frame_done, pixel_count, err
  );

  modport slave (
    input  din,
    output rgb_out, valid, pixel_idx, frame_done, pixel_count, err
  );
endinterface

// File: rtl/led_stream_decoder_sync_2ff.sv
// Two-flop synchronizer for the asynchronous LED line; both stages clear
// to 0 so a freshly reset decoder sees a quiet (low) line.
module led_stream_decoder_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // Capture the async input through two back-to-back flops
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/led_stream_decoder.sv
// Receive side of the WS2812-style single-wire LED protocol. High pulses are
// timed with one shared run-length counter and classified as 0/1, assembled
// MSB-first into 24-bit words, and a long low (latch gap) closes the frame.
module led_stream_decoder
  import led_stream_decoder_pkg::*;
#(
  parameter int T_THRESH = T_THRESH_DEF,
  parameter int T_MIN_HI = T_MIN_HI_DEF,
  parameter int T_MAX_HI = T_MAX_HI_DEF,
  parameter int T_RESET  = T_RESET_DEF,
  parameter int MAX_PIX  = MAX_PIX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  led_stream_decoder_if.slave  bus
);
  localparam int PW = $clog2(MAX_PIX + 1);
  localparam int CW = $clog2(T_RESET + 1);
  localparam int BW = $clog2(LED_BITS);

  logic                s_din_s;
  logic                din_prev_r;
  logic [CW-1:0]       cnt_r;
  state_t              state_r, state_nxt_s;
  logic [LED_BITS-1:0] shift_r, shift_nxt_s;
  logic [BW-1:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic [PW-1:0]       words_r, words_nxt_s;
  logic [LED_BITS-1:0] rgb_r, rgb_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic [PW-1:0]       pixel_idx_r, pixel_idx_nxt_s;
  logic                frame_done_r, frame_done_nxt_s;
  logic [PW-1:0]       pixel_count_r, pixel_count_nxt_s;
  logic                err_r, err_nxt_s;

  logic                rise_s, fall_s, edge_s, quiet_low_s, bit_s;
  logic [LED_BITS-1:0] shifted_s;

  led_stream_decoder_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.din),
    .q   (s_din_s)
  );

  // cnt_r holds how many cycles the line sat at its level before the current
  // cycle, so on the cycle a fall is seen it equals the full high length.
  assign edge_s      = s_din_s ^ din_prev_r;
  assign rise_s      = s_din_s & ~din_prev_r;
  assign fall_s      = ~s_din_s & din_prev_r;
  // True on the cycle the low run reaches T_RESET cycles (this one included).
  assign quiet_low_s = ~s_din_s & ~din_prev_r & (cnt_r >= CW'(T_RESET - 1));
  assign bit_s       = (cnt_r >= CW'(T_THRESH));
  assign shifted_s   = {shift_r[LED_BITS-2:0], bit_s};

  // Previous synchronized level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      din_prev_r <= 1'b0;
    end else begin
      din_prev_r <= s_din_s;
    end
  end

  // Run-length counter: restarts on every edge, saturates at T_RESET
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (edge_s) begin
      cnt_r <= CW'(1);
    end else if (cnt_r < CW'(T_RESET)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, word assembly and output pulse decode
  always_comb begin
    state_nxt_s       = state_r;
    shift_nxt_s       = shift_r;
    bit_cnt_nxt_s     = bit_cnt_r;
    words_nxt_s       = words_r;
    rgb_nxt_s         = rgb_r;
    valid_nxt_s       = 1'b0;
    pixel_idx_nxt_s   = pixel_idx_r;
    frame_done_nxt_s  = 1'b0;
    pixel_count_nxt_s = pixel_count_r;
    err_nxt_s         = 1'b0;
    case (state_r)
      SYNC: begin
        if (quiet_low_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HIGH: begin
        if (cnt_r > CW'(T_MAX_HI)) begin
          // Overlong high: abandon the frame and resynchronise.
          err_nxt_s     = 1'b1;
          state_nxt_s   = SYNC;
          shift_nxt_s   = {LED_BITS{1'b0}};
          bit_cnt_nxt_s = {BW{1'b0}};
          words_nxt_s   = {PW{1'b0}};
        end else if (fall_s) begin
          if (cnt_r < CW'(T_MIN_HI)) begin
            // Glitch: abandon the frame and resynchronise.
            err_nxt_s     = 1'b1;
            state_nxt_s   = SYNC;
            shift_nxt_s   = {LED_BITS{1'b0}};
            bit_cnt_nxt_s = {BW{1'b0}};
            words_nxt_s   = {PW{1'b0}};
          end else begin
            state_nxt_s = LOW;
            if (bit_cnt_r == BW'(LED_BITS - 1)) begin
              bit_cnt_nxt_s = {BW{1'b0}};
              shift_nxt_s   = {LED_BITS{1'b0}};
              if (words_r == PW'(MAX_PIX)) begin
                // Frame already full: drop the word, keep the frame open.
                err_nxt_s = 1'b1;
              end else begin
                rgb_nxt_s       = shifted_s;
                valid_nxt_s     = 1'b1;
                pixel_idx_nxt_s = words_r;
                words_nxt_s     = words_r + PW'(1);
              end
            end else begin
              shift_nxt_s   = shifted_s;
              bit_cnt_nxt_s = bit_cnt_r + BW'(1);
            end
          end
        end else begin
          state_nxt_s = HIGH;
        end
      end
      LOW: begin
        if (rise_s) begin
          state_nxt_s = HIGH;
        end else if (quiet_low_s) begin
          // Latch gap: report the frame; leftover bits are an error.
          state_nxt_s       = IDLE;
          frame_done_nxt_s  = 1'b1;
          pixel_count_nxt_s = words_r;
          err_nxt_s         = (bit_cnt_r != {BW{1'b0}});
          words_nxt_s       = {PW{1'b0}};
          bit_cnt_nxt_s     = {BW{1'b0}};
          shift_nxt_s       = {LED_BITS{1'b0}};
          pixel_idx_nxt_s   = {PW{1'b0}};
        end else begin
          state_nxt_s = LOW;
        end
      end
      default: begin
        state_nxt_s = SYNC;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r       <= {LED_BITS{1'b0}};
      bit_cnt_r     <= {BW{1'b0}};
      words_r       <= {PW{1'b0}};
      rgb_r         <= {LED_BITS{1'b0}};
      valid_r       <= 1'b0;
      pixel_idx_r   <= {PW{1'b0}};
      frame_done_r  <= 1'b0;
      pixel_count_r <= {PW{1'b0}};
      err_r         <= 1'b0;
    end else begin
      shift_r       <= shift_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      words_r       <= words_nxt_s;
      rgb_r         <= rgb_nxt_s;
      valid_r       <= valid_nxt_s;
      pixel_idx_r   <= pixel_idx_nxt_s;
      frame_done_r  <= frame_done_nxt_s;
      pixel_count_r <= pixel_count_nxt_s;
      err_r         <= err_nxt_s;
    end
  end

  assign bus.rgb_out     = rgb_r;
  assign bus.valid       = valid_r;
  assign bus.pixel_idx   = pixel_idx_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.pixel_count = pixel_count_r;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_led_stream_decoder.sv
// Bench for led_stream_decoder: drives timed pulses on din, pushes the
// expected output events onto a queue as stimulus goes out, and compares
// against events captured from the DUT.
module tb_led_stream_decoder;
  import led_stream_decoder_pkg::*;

  localparam int PW = pix_width(MAX_PIX_DEF);

  typedef struct packed {
    logic                v;
    logic                fd;
    logic                er;
    logic [LED_BITS-1:0] rgb;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_idx = 0;
  int   fall_cyc = 0;
  int   valid_cyc = -1;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  mon_ev;

  led_stream_decoder_if #(.PW(PW)) bus ();

  led_stream_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every cycle carrying valid, err or frame_done
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.valid !== 1'b0 || bus.err !== 1'b0 || bus.frame_done !== 1'b0)) begin
      mon_ev    = '0;
      mon_ev.v  = bus.valid;
      mon_ev.fd = bus.frame_done;
      mon_ev.er = bus.err;
      if (bus.valid === 1'b1) begin
        mon_ev.rgb = bus.rgb_out;
        mon_ev.idx = bus.pixel_idx;
        valid_cyc  = cyc;
      end
      if (bus.frame_done === 1'b1) mon_ev.cnt = bus.pixel_count;
      obs_q.push_back(mon_ev);
    end
  end

  task automatic gap(input int n);
    bus.din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.din = 1'b1;
    repeat (hi) @(negedge clk);
    bus.din = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(T1H, T_BIT - T1H);
    else   pulse(T0H, T_BIT - T0H);
  endtask

  task automatic push_word(input logic [LED_BITS-1:0] w);
    ev_t e;
    e = '0; e.v = 1'b1; e.rgb = w; e.idx = PW'(exp_idx);
    exp_q.push_back(e);
    exp_idx++;
  endtask

  task automatic send_word(input logic [LED_BITS-1:0] w);
    push_word(w);
    for (int i = LED_BITS - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic end_frame(input logic partial);
    ev_t e;
    e = '0; e.fd = 1'b1; e.er = partial; e.cnt = PW'(exp_idx);
    exp_q.push_back(e);
    exp_idx = 0;
    gap(T_RESET_DEF + 20);
  endtask

  task automatic expect_err();
    ev_t e;
    e = '0; e.er = 1'b1;
    exp_q.push_back(e);
    exp_idx = 0;
  endtask

  task automatic test_reset();
    logic [LED_BITS-1:0] w;
    bus.din = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.rgb_out !== 24'h000000) begin failures++; $display("FAIL reset_rgb: got %h want 000000", bus.rgb_out); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    checks++; if (bus.pixel_idx !== {PW{1'b0}}) begin failures++; $display("FAIL reset_idx: got %0d want 0", bus.pixel_idx); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
    checks++; if (bus.pixel_count !== {PW{1'b0}}) begin failures++; $display("FAIL reset_count: got %0d want 0", bus.pixel_count); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.err); end
    // A word straight out of reset arrives before the line was quiet: ignored.
    w = 24'h00CEFF;
    for (int i = LED_BITS - 1; i >= 0; i--) send_bit(w[i]);
    gap(T_RESET_DEF + 20);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_ignore: observed %0d events, required 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete(); exp_idx = 0;
  endtask

  task automatic test_single_word();
    ev_t e, o;
    valid_cyc = -1;
    send_word(24'h00CEFF);
    end_frame(1'b0);
    checks++;
    if (valid_cyc != fall_cyc + 3) begin
      failures++;
      $display("FAIL single_latency: valid at cycle %0d, required %0d", valid_cyc, fall_cyc + 3);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL single_event: observed %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    send_word(24'hFFFFFF);
    send_word(24'h000000);
    send_word(24'hA5A55A);
    end_frame(1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_event: observed %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_boundaries();
    ev_t e, o;
    int  hi;
    logic [LED_BITS-1:0] w;
    // 72 -> 1 (longest legal), 4 -> 0 (shortest legal), then 29 -> 1, 28 -> 0.
    push_word(24'hAAAAAA);
    for (int i = 0; i < LED_BITS; i++) begin
      if (i == 0)          hi = T_MAX_HI_DEF;
      else if (i == 1)     hi = T_MIN_HI_DEF;
      else if (i % 2 == 0) hi = T_THRESH_DEF;
      else                 hi = T_THRESH_DEF - 1;
      pulse(hi, 30);
    end
    end_frame(1'b0);
    // Overlong high, then recovery.
    pulse(T_MAX_HI_DEF + 1, 10);
    expect_err();
    gap(T_RESET_DEF + 20);
    send_word(24'h123456);
    end_frame(1'b0);
    // Glitch, then recovery.
    pulse(3, 10);
    expect_err();
    gap(T_RESET_DEF + 20);
    send_word(24'h123456);
    end_frame(1'b0);
    // A low one cycle short of the latch gap stays inside the word.
    w = 24'h5A3C96;
    push_word(w);
    for (int i = LED_BITS - 1; i >= 0; i--) begin
      if (i == 12) pulse(w[i] ? T1H : T0H, T_RESET_DEF - 1);
      else         send_bit(w[i]);
    end
    end_frame(1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bound_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL bound_event: observed %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_partial();
    ev_t e, o;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    end_frame(1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL partial_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL partial_event: observed %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midword();
    ev_t e, o;
    logic [LED_BITS-1:0] w;
    send_word(24'h111111);
    end_frame(1'b0);
    w = 24'h3C3C3C;
    for (int i = LED_BITS - 1; i >= 12; i--) send_bit(w[i]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.rgb_out !== 24'h000000) begin failures++; $display("FAIL mid_rgb: got %h want 000000", bus.rgb_out); end
    checks++; if (bus.pixel_count !== {PW{1'b0}}) begin failures++; $display("FAIL mid_count: got %0d want 0", bus.pixel_count); end
    checks++; if (bus.valid !== 1'b0 || bus.err !== 1'b0 || bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL mid_pulses: got v=%b e=%b fd=%b want 0 0 0", bus.valid, bus.err, bus.frame_done);
    end
    exp_idx = 0;
    gap(T_RESET_DEF + 20);
    send_word(24'hC0FFEE);
    end_frame(1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL mid_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL mid_event: observed %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.din = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_boundaries();
    test_partial();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
